// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer
// Function : Direct-mapped branch target buffer. Each entry holds a valid
//            bit, a tag, a target address and a 2-bit saturating counter.
//            The lookup on the fetch PC is combinational. The execute stage
//            trains the table with a single write per clock.
// Revision : 1.0  initial release
// ============================================================================
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        predicted_taken,
    output logic [31:0] predicted_target,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;

    // Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] c_ctr_reset      = 2'b01;
    localparam logic [1:0] c_ctr_weak_taken = 2'b10;
    localparam logic [1:0] c_ctr_max        = 2'b11;
    localparam logic [1:0] c_ctr_min        = 2'b00;

    // Table storage
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    // Fetch-side address split
    logic [IDX-1:0]     w_fetch_idx;
    logic [TAG_W-1:0]   w_fetch_tag;
    logic               w_fetch_hit;

    // Update-side address split
    logic [IDX-1:0]     w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic [1:0]         w_ctr_next;

    // Instructions are word aligned, so the two low PC bits carry no information.
    logic               w_unused_pc_bits;
    assign w_unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

    assign w_fetch_idx = fetch_pc[IDX+1:2];
    assign w_fetch_tag = fetch_pc[31:IDX+2];
    assign w_upd_idx   = update_pc[IDX+1:2];
    assign w_upd_tag   = update_pc[31:IDX+2];

    // Lookup reads current table contents only; there is no write bypass.
    assign w_fetch_hit      = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    assign predicted_taken  = w_fetch_hit && r_ctr[w_fetch_idx][1];
    assign predicted_target = predicted_taken ? r_target[w_fetch_idx] : (fetch_pc + 32'd4);

    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // Saturating counter step for the entry being trained
    always_comb begin
        w_ctr_next = r_ctr[w_upd_idx];
        if (update_taken) begin
            if (r_ctr[w_upd_idx] != c_ctr_max) begin
                w_ctr_next = r_ctr[w_upd_idx] + 2'd1;
            end
        end else begin
            if (r_ctr[w_upd_idx] != c_ctr_min) begin
                w_ctr_next = r_ctr[w_upd_idx] - 2'd1;
            end
        end
    end

    // Table training: hits adjust the counter, taken misses allocate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_ctr_reset;
            end
        end else if (update_en) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= w_ctr_next;
                if (update_taken) begin
                    r_target[w_upd_idx] <= update_target;
                end
            end else if (update_taken) begin
                // Not-taken misses are never allocated.
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= update_target;
                r_ctr[w_upd_idx]    <= c_ctr_weak_taken;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-stage predictor that produces the predicted-taken flag and predicted target consumed by the execute-stage branch resolver, and is trained by that resolver's outcome. It is a direct-mapped table of valid bit, tag, target address and 2-bit saturating counter. Lookup is combinational on the fetch PC. Training is a single-cycle synchronous write driven by the execute stage's resolved branch/jump result.

## Interface
- ENTRIES, 16: number of table entries; power of two, at least 2. IDX = log2(ENTRIES).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_pc  input  32  PC of the instruction being fetched.
- predicted_taken  output  1  lookup hit and counter in a taken state.
- predicted_target  output  32  stored target on hit; fetch_pc + 4 otherwise.
- update_en  input  1  execute stage holds a resolved branch/jump (JAL, JALR or B-type) this cycle.
- update_pc  input  32  PC of the resolved instruction.
- update_target  input  32  resolved jump/branch target (JALR target already has bit 0 cleared).
- update_taken  input  1  resolved outcome: 1 = jump or taken branch.

## Operation
- Address split:
  - index = pc[IDX+1:2].
  - tag = pc[31:IDX+2].
  - pc[1:0] is ignored.
- Entry state: valid (1), tag (30-IDX), target (32), ctr (2).
- Lookup (combinational):
  - hit = valid[index] && tag[index] == fetch_pc tag.
  - predicted_taken = hit && ctr[index][1].
  - predicted_target = predicted_taken ? target[index] : fetch_pc + 4, with 32-bit wraparound (0xFFFFFFFC + 4 = 0x00000000).
- Training (on a clock edge with update_en=1):
  - **Update hit** (valid and tag match at the update index):
    - update_taken=1: ctr saturating increment (max 2'b11) and target := update_target.
    - update_taken=0: ctr saturating decrement (min 2'b00); target unchanged.
  - **Update miss, update_taken=1**: allocate or replace the entry. valid := 1, tag := update_pc tag, target := update_target, ctr := 2'b10 (weakly taken).
  - **Update miss, update_taken=0**: no state change. Not-taken branches are never allocated.
- With update_en=0, no state changes.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.

## Timing
- Lookup has zero latency (combinational from fetch_pc and current table state).
- Training is visible to lookups from the cycle after the update edge.
- Same-cycle lookup and update at the same index: lookup returns the pre-update contents. There is no write-to-read bypass.
- Only one update per cycle, so there is no write conflict.
- Reset:
  - On rst assertion, without waiting for clk: all valid := 0, all ctr := 2'b01, targets and tags := 0.
  - predicted_taken = 0 and predicted_target = fetch_pc + 4 while rst is high and immediately after.
  - Reset asserted mid-update discards that update.
- Deassertion of rst is synchronous to clk from the user's side; the first training edge is the first rising edge with rst low.

## Test plan
- **Reset lookup:** assert rst, fetch_pc=0x00000100 -> predicted_taken=0, predicted_target=0x00000104.
- **Allocate on taken:** update_en=1, update_pc=0x100, update_target=0x200, update_taken=1 for one edge.
  - Next cycle, fetch_pc=0x100 -> predicted_taken=1, predicted_target=0x200.
  - In the update cycle itself, the same lookup -> predicted_taken=0.
- **Counter hysteresis:** from the allocated entry (ctr=10):
  - One not-taken update -> predicted_taken=0.
  - Three taken updates -> ctr=11.
  - One more taken update -> still 11.
  - One not-taken -> ctr=10, predicted_taken=1.
  - Two more not-taken -> ctr=00.
  - Further not-taken -> still 00.
- **Aliasing (ENTRIES=16):** entry 0x100 is trained taken.
  - Lookup 0x140 (same index 0, different tag) -> predicted_taken=0.
  - Not-taken update at 0x140 leaves lookup 0x100 still predicted_taken=1.
  - Taken update 0x140 -> 0x300 makes 0x140 predict 0x300 and 0x100 miss.
- **Wraparound / no-allocate:**
  - Miss lookup 0xFFFFFFFC -> predicted_target=0x00000000.
  - Not-taken update at an empty index leaves valid=0.
- **Async reset mid-operation:** after training several entries, pulse rst between clock edges.
  - All lookups show predicted_taken=0 before the next edge.
  - An update_en asserted in the reset cycle has no effect.
